button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end stage for the stopwatch mode FSM. It turns the raw asynchronous push-button into clean single-cycle events.
- Processing chain: 2-flop synchronizer, then debounce filter, then edge detection (press/release), then a long-press (hold) detector.
- press_pulse_o drives the mode FSM's advance input directly. hold_pulse_o is reserved for a future hold-to-clear feature.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronized input must differ from the debounced state before the state flips; legal range >= 1.
- HOLD_CYCLES, 24: cycles after press_pulse_o at which hold_pulse_o fires if still pressed; legal range >= 1.
- DB_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width (derived; do not override).
- HOLD_W, $clog2(HOLD_CYCLES+1): hold counter width (derived; do not override).

Ports:
- clk  input  1  system clock (12 MHz)
- RST  input  1  synchronous, active-low reset; sampled on rising clk edge only
- button_i  input  1  raw asynchronous button, active high
- pressed_o  output  1  debounced button level
- press_pulse_o  output  1  one-cycle pulse on debounced rising edge
- release_pulse_o  output  1  one-cycle pulse on debounced falling edge
- hold_pulse_o  output  1  one-cycle pulse on long press, at most once per press

Behaviour:
- Reset (RST==0 at a rising edge):
  - sync flops, stable state, both counters and all outputs go to 0.
  - Reset mid-debounce or mid-hold discards progress; no pulse is emitted on the reset edge.
- Synchronizer:
  - sync1 <= button_i; sync2 <= sync1. Only sync2 is used downstream.
- Debounce counter db_cnt:
  - If sync2 == stable, db_cnt <= 0.
  - Else if db_cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and db_cnt <= 0.
  - Else db_cnt <= db_cnt+1.
  - Any agreement cycle restarts the count, so glitches shorter than DEBOUNCE_CYCLES produce no output.
- Latency:
  - Let edge k be the first edge at which button_i is sampled 1, with the button held afterwards.
  - pressed_o rises at edge k+DEBOUNCE_CYCLES+1 (k+5 at default).
  - Release latency is symmetric.
- Outputs:
  - All registered; no combinational path from button_i.
  - pressed_o = stable.
  - press_pulse_o is high for exactly the one cycle following the edge at which stable goes 0->1.
  - release_pulse_o is the same for 1->0.
  - The press and release pulses are never both high.
- Hold detector:
  - hold_cnt is cleared whenever stable==0 and on the edge stable rises.
  - While stable==1 and hold_cnt < HOLD_CYCLES, hold_cnt increments.
  - hold_pulse_o is high for one cycle when hold_cnt transitions HOLD_CYCLES-1 -> HOLD_CYCLES, which is HOLD_CYCLES cycles after press_pulse_o.
  - hold_cnt then saturates; no further hold pulses until a release and a new press.
- Simultaneous events:
  - If stable falls on the same edge the hold count would complete, release wins: release_pulse_o=1, hold_pulse_o=0, hold_cnt cleared.
- Button held through reset:
  - Since stable resets to 0, a held button yields press_pulse_o DEBOUNCE_CYCLES+1 cycles after the sync flops see 1 following reset deassertion.
  - Downstream relies on this.
- Counter widths:
  - Counters are never compared beyond their terminal values, so no wrap-around occurs.
  - A 1-cycle counter is legal when DEBOUNCE_CYCLES==1; a 0-bit counter is never generated.

Test Plan:
- Reset: hold RST=0 for 2 cycles with button_i=1 -> all outputs 0. Release RST at edge r with button_i still held -> press_pulse_o high for exactly one cycle after edge r+5, pressed_o=1 thereafter.
- Clean press: button_i 0->1 sampled at edge k and held 40 cycles -> pressed_o rises at k+5; press_pulse_o high one cycle. hold_pulse_o high exactly one cycle, 24 cycles after press_pulse_o. No second hold pulse. Release -> release_pulse_o one cycle, 5 cycles after the first 0 sample.
- Bounce rejection: button_i toggles 1,0,1,1,0,1,1,1,0 (every run < 4 cycles) -> pressed_o stays 0, no pulses. Then hold 1 for 10 cycles -> exactly one press_pulse_o.
- Short press: hold 1 for 10 cycles, then 0 -> one press pulse, one release pulse, zero hold pulses, pressed_o high for 10 cycles.
- Reset mid-operation: press held, assert RST=0 for one edge 20 cycles after press_pulse_o -> outputs cleared immediately, no hold pulse. After RST=1 with button still held -> new press_pulse_o at +5, hold_pulse_o 24 cycles later.
- Boundary params: DEBOUNCE_CYCLES=1, HOLD_CYCLES=1 -> press detected 2 edges after first sample; hold_pulse_o on the cycle after press_pulse_o. Release on the hold-completion edge -> release_pulse_o only.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw button in, conditioned level and pulses out.
//   button_i        raw asynchronous button, active high
//   pressed_o       debounced button level
//   press_pulse_o   one-cycle pulse on debounced rising edge
//   release_pulse_o one-cycle pulse on debounced falling edge
//   hold_pulse_o    one-cycle pulse on long press, at most once per press
// master: the side that owns the button and consumes the events.
// slave : the conditioner itself.
interface button_conditioner_if;
   logic button_i;
   logic pressed_o;
   logic press_pulse_o;
   logic release_pulse_o;
   logic hold_pulse_o;

   modport master (
      output button_i,
      input  pressed_o,
      input  press_pulse_o,
      input  release_pulse_o,
      input  hold_pulse_o
   );

   modport slave (
      input  button_i,
      output pressed_o,
      output press_pulse_o,
      output release_pulse_o,
      output hold_pulse_o
   );
endinterface

// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchronizer, debounce filter, press/release
// edge detection and a long-press (hold) detector. All outputs registered.
//   clk  system clock
//   RST  synchronous, active-low reset
//   bus  button_conditioner_if.slave (button_i in; pressed_o, press_pulse_o,
//        release_pulse_o, hold_pulse_o out)
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES     = 24,
   parameter int unsigned DB_W            = $clog2(DEBOUNCE_CYCLES + 1),
   parameter int unsigned HOLD_W          = $clog2(HOLD_CYCLES + 1)
) (
   input  logic                 clk,
   input  logic                 RST,
   button_conditioner_if.slave  bus
);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

   logic              sync1;
   logic              sync2;
   logic              stable;
   logic              stable_next;
   logic [DB_W-1:0]   db_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              press_q;
   logic              release_q;
   logic              hold_q;

   // Next debounced state, shared by the state update and the edge pulses so
   // the pulses land in the cycle right after the flip.
   always_comb begin
      stable_next = stable;
      if (sync2 != stable && db_cnt == DB_LAST) begin
         stable_next = sync2;
      end
   end

   always_ff @(posedge clk) begin
      if (!RST) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         stable    <= 1'b0;
         db_cnt    <= '0;
         hold_cnt  <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         hold_q    <= 1'b0;
      end else begin
         sync1 <= bus.button_i;
         sync2 <= sync1;

         // Any agreement cycle restarts the run of disagreements.
         if (sync2 == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end

         stable    <= stable_next;
         press_q   <= !stable && stable_next;
         release_q <= stable && !stable_next;

         // Counting only while pressed before and after this edge: this clears
         // on the rising edge and lets a release beat a completing hold.
         hold_q <= 1'b0;
         if (!(stable && stable_next)) begin
            hold_cnt <= '0;
         end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
            hold_q   <= (hold_cnt == HOLD_LAST);
         end
      end
   end

   assign bus.pressed_o       = stable;
   assign bus.press_pulse_o   = press_q;
   assign bus.release_pulse_o = release_q;
   assign bus.hold_pulse_o    = hold_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a default instance (4/24) and a boundary
// instance (1/1) share one button/reset stimulus. A reference model derives
// expected outputs from the sample history each edge.
module tb_button_conditioner;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic button = 1'b0;

   always #5 clk = ~clk;

   button_conditioner_if bus0 ();
   button_conditioner_if bus1 ();
   assign bus0.button_i = button;
   assign bus1.button_i = button;

   button_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(24)) u_dut0 (
      .clk (clk),
      .RST (rst_n),
      .bus (bus0.slave)
   );

   button_conditioner #(.DEBOUNCE_CYCLES(1), .HOLD_CYCLES(1)) u_dut1 (
      .clk (clk),
      .RST (rst_n),
      .bus (bus1.slave)
   );

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   // Reference model state
   int D[2] = '{4, 1};
   int H[2] = '{24, 1};
   bit btn_q[$];
   int n = -1;
   int last_rst = -1000;
   bit m_stable[2];
   int m_rise[2];
   bit e_press[2], e_rel[2], e_hold[2];

   // Observed event bookkeeping for directed checks
   int cnt_press[2], cnt_rel[2], cnt_hold[2], cnt_high[2];
   int p_edge[2], h_edge[2];

   // Value the second sync stage presents before edge m: the button sampled
   // two edges earlier, or 0 if a reset edge intervened.
   function automatic bit s2(int m);
      if (m - 2 > last_rst && m - 2 >= 0) return btn_q[m - 2];
      return 1'b0;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, n);
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 2; i++) begin
         cnt_press[i] = 0; cnt_rel[i] = 0; cnt_hold[i] = 0; cnt_high[i] = 0;
         p_edge[i] = -1; h_edge[i] = -1;
      end
   endtask

   task automatic step(input bit b, input bit r);
      bit v, flip;
      logic ob[2][4];
      button = b;
      rst_n  = r;
      @(posedge clk);
      n++;
      btn_q.push_back(b);
      for (int i = 0; i < 2; i++) begin
         e_press[i] = 0; e_rel[i] = 0; e_hold[i] = 0;
         if (!r) begin
            last_rst    = n;
            m_stable[i] = 0;
            m_rise[i]   = -1000;
         end else begin
            // Flip once the last D pre-edge samples all disagree with the state.
            v = !m_stable[i];
            flip = 1;
            for (int j = 0; j < D[i]; j++) if (s2(n - j) != v) flip = 0;
            if (flip) begin
               m_stable[i] = v;
               e_press[i]  = v;
               e_rel[i]    = !v;
               if (v) m_rise[i] = n;
            end
            e_hold[i] = m_stable[i] && (n - m_rise[i] == H[i]);
         end
      end
      #1;
      ob[0] = '{bus0.pressed_o, bus0.press_pulse_o, bus0.release_pulse_o, bus0.hold_pulse_o};
      ob[1] = '{bus1.pressed_o, bus1.press_pulse_o, bus1.release_pulse_o, bus1.hold_pulse_o};
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("pressed%0d", i), 32'(ob[i][0]), 32'(m_stable[i]));
         chk($sformatf("press%0d", i),   32'(ob[i][1]), 32'(e_press[i]));
         chk($sformatf("release%0d", i), 32'(ob[i][2]), 32'(e_rel[i]));
         chk($sformatf("hold%0d", i),    32'(ob[i][3]), 32'(e_hold[i]));
         if (ob[i][0] === 1'b1) cnt_high[i]++;
         if (ob[i][1] === 1'b1) begin cnt_press[i]++; p_edge[i] = n; end
         if (ob[i][2] === 1'b1) cnt_rel[i]++;
         if (ob[i][3] === 1'b1) begin cnt_hold[i]++; h_edge[i] = n; end
      end
   endtask

   task automatic run(input bit b, input int len);
      for (int j = 0; j < len; j++) step(b, 1'b1);
   endtask

   initial begin
      bit pat[9];
      pat = '{1, 0, 1, 1, 0, 1, 1, 1, 0};

      // Reset with button held, then release reset keeping it held
      clear_counts();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      run(1'b1, 40);
      chk("rst_hold_press_cnt", cnt_press[0], 1);
      chk("rst_hold_hold_cnt", cnt_hold[0], 1);
      chk("rst_hold_delay", h_edge[0] - p_edge[0], 24);
      clear_counts();
      run(1'b0, 10);
      chk("release_cnt", cnt_rel[0], 1);

      // Bounce rejection
      clear_counts();
      for (int j = 0; j < 9; j++) step(pat[j], 1'b1);
      run(1'b0, 6);
      chk("bounce_press_cnt", cnt_press[0], 0);
      chk("bounce_high_cnt", cnt_high[0], 0);
      clear_counts();
      run(1'b1, 10);
      chk("after_bounce_press_cnt", cnt_press[0], 1);
      run(1'b0, 10);

      // Short press
      clear_counts();
      run(1'b1, 10);
      run(1'b0, 10);
      chk("short_press_cnt", cnt_press[0], 1);
      chk("short_release_cnt", cnt_rel[0], 1);
      chk("short_hold_cnt", cnt_hold[0], 0);
      chk("short_high_cycles", cnt_high[0], 10);

      // Reset 20 cycles after the press pulse, button kept held
      clear_counts();
      run(1'b1, 25);
      chk("mid_hold_before_rst", cnt_hold[0], 0);
      step(1'b1, 1'b0);
      run(1'b1, 40);
      chk("mid_press_cnt", cnt_press[0], 2);
      chk("mid_hold_cnt", cnt_hold[0], 1);
      chk("mid_hold_delay", h_edge[0] - p_edge[0], 24);
      run(1'b0, 10);

      // Boundary instance: release on the hold-completion edge
      clear_counts();
      run(1'b1, 1);
      run(1'b0, 5);
      chk("b1_race_press", cnt_press[1], 1);
      chk("b1_race_release", cnt_rel[1], 1);
      chk("b1_race_hold", cnt_hold[1], 0);
      chk("b0_glitch_press", cnt_press[0], 0);

      // Boundary instance: clean press, hold one cycle after press
      clear_counts();
      run(1'b1, 5);
      chk("b1_hold_cnt", cnt_hold[1], 1);
      chk("b1_hold_delay", h_edge[1] - p_edge[1], 1);
      run(1'b0, 5);

      // Random runs with occasional reset
      for (int k = 0; k < 800; ) begin
         bit v;
         int len;
         v   = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 30));
         if ($urandom_range(0, 40) == 0) step(v, 1'b0);
         run(v, len);
         k += len;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
